cla_pipe: RTL and testbench



---
 rtl/cla_pipe_if.sv | 39 +++
 rtl/cla_pipe.sv | 177 +++++++++++++++++
 tb/tb_cla_pipe.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_if.sv
// cla_pipe_if: operand/result handshake bundle for cla_pipe.
//   master (producer/consumer side): drives A, B, CIN, IN_VALID, OUT_READY;
//                                    observes IN_READY, S, Cout, OUT_VALID (and OVF).
//   slave  (adder side):             the mirror image.
// Optional macro CLA_PIPE_OVF_EN adds the OVF result signal.
interface cla_pipe_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             OUT_VALID;
  logic             OUT_READY;
`ifdef CLA_PIPE_OVF_EN
  logic             OVF;

  modport master (
    output A, B, CIN, IN_VALID, OUT_READY,
    input  IN_READY, S, Cout, OUT_VALID, OVF
  );
  modport slave (
    input  A, B, CIN, IN_VALID, OUT_READY,
    output IN_READY, S, Cout, OUT_VALID, OVF
  );
`else
  modport master (
    output A, B, CIN, IN_VALID, OUT_READY,
    input  IN_READY, S, Cout, OUT_VALID
  );
  modport slave (
    input  A, B, CIN, IN_VALID, OUT_READY,
    output IN_READY, S, Cout, OUT_VALID
  );
`endif
endinterface

// File: rtl/cla_pipe.sv
// cla_pipe: pipelined carry-lookahead adder, one GRP-bit lookahead group per stage.
//   CLK    : rising-edge clock
//   RST_N  : asynchronous active-low reset, clears every stage immediately
//   cla_io : slave side of cla_pipe_if
//            A/B/CIN/IN_VALID/IN_READY  operand handshake
//            S/Cout/OUT_VALID/OUT_READY result handshake (S/Cout are the last stage)
// Latency is NGRP = WIDTH/GRP cycles; the pipe collapses bubbles and accepts a new
// operand set while full as long as the result is being popped in the same cycle.
// Optional macro CLA_PIPE_OVF_EN adds OVF, the registered signed overflow flag.
module cla_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GRP   = 8
) (
  input logic         CLK,
  input logic         RST_N,
  cla_pipe_if.slave   cla_io
);

  localparam int unsigned NGRP  = WIDTH / GRP;
  localparam int unsigned NCELL = GRP / 4;

  // Adds one group: returns {carry_out, sum}. Carries into each 4-bit cell are flat
  // sum-of-products over the lower cells' generate/propagate, so no cell waits on
  // the carry of its neighbour.
  function automatic logic [GRP:0] grp_add(input logic [GRP-1:0] ga,
                                           input logic [GRP-1:0] gb,
                                           input logic           ci);
    logic [GRP-1:0]   p, g, c;
    logic [NCELL-1:0] cg, cp;
    logic [NCELL:0]   cc;
    logic             term;
    p = ga ^ gb;
    g = ga & gb;
    for (int j = 0; j < NCELL; j++) begin
      cg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      cp[j] = &p[4*j +: 4];
    end
    cc    = '0;
    cc[0] = ci;
    for (int j = 1; j <= NCELL; j++) begin
      term = ci;
      for (int m = 0; m < j; m++) term = term & cp[m];
      cc[j] = term;
      for (int i = 0; i < j; i++) begin
        term = cg[i];
        for (int m = i + 1; m < j; m++) term = term & cp[m];
        cc[j] = cc[j] | term;
      end
    end
    for (int j = 0; j < NCELL; j++) begin
      c[4*j]   = cc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & cc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & cc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                 (p[4*j+2] & p[4*j+1] & p[4*j] & cc[j]);
    end
    return {cc[NCELL], p ^ c};
  endfunction

  // Stage state: valid, operands carried forward, resolved sum bits, group carry.
  logic [NGRP-1:0]  v_q, v_d;
  logic [NGRP-1:0]  c_q, c_d;
  logic [WIDTH-1:0] a_q [NGRP];
  logic [WIDTH-1:0] a_d [NGRP];
  logic [WIDTH-1:0] b_q [NGRP];
  logic [WIDTH-1:0] b_d [NGRP];
  logic [WIDTH-1:0] s_q [NGRP];
  logic [WIDTH-1:0] s_d [NGRP];

  // What each stage would load: stage 0 sees the input port, stage k sees stage k-1.
  logic [NGRP-1:0]  in_v, in_c, ld;
  logic [WIDTH-1:0] in_a [NGRP];
  logic [WIDTH-1:0] in_b [NGRP];
  logic [WIDTH-1:0] in_s [NGRP];
  logic [WIDTH-1:0] nsum [NGRP];
  logic [GRP:0]     grp_r [NGRP];

  always_comb begin
    in_v[0] = cla_io.IN_VALID;
    in_c[0] = cla_io.CIN;
    in_a[0] = cla_io.A;
    in_b[0] = cla_io.B;
    in_s[0] = '0;
    for (int k = 1; k < NGRP; k++) begin
      in_v[k] = v_q[k-1];
      in_c[k] = c_q[k-1];
      in_a[k] = a_q[k-1];
      in_b[k] = b_q[k-1];
      in_s[k] = s_q[k-1];
    end
  end

  // A stage may load if it or any stage downstream of it is empty, or the output pops.
  always_comb begin
    for (int k = 0; k < NGRP; k++) begin
      ld[k] = cla_io.OUT_READY;
      for (int j = k; j < NGRP; j++) ld[k] = ld[k] | ~v_q[j];
    end
  end

  always_comb begin
    for (int k = 0; k < NGRP; k++) begin
      grp_r[k]                 = grp_add(in_a[k][k*GRP +: GRP], in_b[k][k*GRP +: GRP], in_c[k]);
      nsum[k]                  = in_s[k];
      nsum[k][k*GRP +: GRP]    = grp_r[k][GRP-1:0];
    end
  end

  always_comb begin
    v_d = v_q;
    c_d = c_q;
    for (int k = 0; k < NGRP; k++) begin
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
    end
    for (int k = 0; k < NGRP; k++) begin
      if (ld[k]) begin
        v_d[k] = in_v[k];
        // Bubbles only clear the valid bit; data is left alone.
        if (in_v[k]) begin
          a_d[k] = in_a[k];
          b_d[k] = in_b[k];
          s_d[k] = nsum[k];
          c_d[k] = grp_r[k][GRP];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v_q <= '0;
      c_q <= '0;
      for (int k = 0; k < NGRP; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      for (int k = 0; k < NGRP; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign cla_io.IN_READY  = ld[0];
  assign cla_io.OUT_VALID = v_q[NGRP-1];
  assign cla_io.S         = s_q[NGRP-1];
  assign cla_io.Cout      = c_q[NGRP-1];

`ifdef CLA_PIPE_OVF_EN
  // Carry into the MSB is a^b^s at that bit; XOR with carry out gives signed overflow.
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (ld[NGRP-1] && in_v[NGRP-1]) begin
      ovf_d = in_a[NGRP-1][WIDTH-1] ^ in_b[NGRP-1][WIDTH-1] ^ nsum[NGRP-1][WIDTH-1] ^
              grp_r[NGRP-1][GRP];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign cla_io.OVF = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe.sv
module tb_cla_pipe;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
  } op_t;

  logic CLK;
  logic RST_N;
  int   n_checks = 0;
  int   n_fail   = 0;
  op_t  exp_q[$];

  cla_pipe_if #(.WIDTH(32)) bus   ();
  cla_pipe_if #(.WIDTH(16)) bus16 ();
  cla_pipe_if #(.WIDTH(64)) bus64 ();
  cla_pipe_if #(.WIDTH(16)) bus1  ();

  cla_pipe #(.WIDTH(32), .GRP(8))  u_dut   (.CLK(CLK), .RST_N(RST_N), .cla_io(bus));
  cla_pipe #(.WIDTH(16), .GRP(4))  u_dut16 (.CLK(CLK), .RST_N(RST_N), .cla_io(bus16));
  cla_pipe #(.WIDTH(64), .GRP(16)) u_dut64 (.CLK(CLK), .RST_N(RST_N), .cla_io(bus64));
  cla_pipe #(.WIDTH(16), .GRP(16)) u_dut1  (.CLK(CLK), .RST_N(RST_N), .cla_io(bus1));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [32:0] ref32(input op_t op);
    return {1'b0, op.a} + {1'b0, op.b} + {32'd0, op.c};
  endfunction

  function automatic logic ref_ovf(input op_t op);
    logic [32:0] r;
    r = ref32(op);
    return (op.a[31] == op.b[31]) && (r[31] != op.a[31]);
  endfunction

  function automatic op_t rand_op();
    op_t op;
    op.a = $urandom;
    op.b = $urandom;
    op.c = 1'($urandom_range(1, 0));
    return op;
  endfunction

  task automatic test_reset();
    RST_N = 1'b0;
    bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
    bus.A = '0; bus.B = '0; bus.CIN = 1'b0;
    #95;
    n_checks++;
    if ({bus.OUT_VALID, bus.Cout, bus.S} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_out: valid/cout/s=%b/%b/%h required 0/0/0",
               bus.OUT_VALID, bus.Cout, bus.S);
    end
`ifdef CLA_PIPE_OVF_EN
    n_checks++;
    if (bus.OVF !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", bus.OVF); end
`endif
    #5 RST_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: in_ready=%b out_valid=%b required 1/0",
               bus.IN_READY, bus.OUT_VALID);
    end
  endtask

  task automatic test_basic();
    @(negedge CLK);
    bus.A = 32'd1232; bus.B = 32'd1456; bus.CIN = 1'b0; bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
    #1;
    n_checks++;
    if (bus.IN_READY !== 1'b1) begin n_fail++; $display("FAIL basic_accept: in_ready=%b required 1", bus.IN_READY); end
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      bus.IN_VALID = 1'b0;
      n_checks++;
      if (bus.OUT_VALID !== (i == 4)) begin
        n_fail++;
        $display("FAIL basic_latency: cycle %0d out_valid=%b required %b", i, bus.OUT_VALID, i == 4);
      end
      if (i == 4) begin
        n_checks++;
        if ({bus.Cout, bus.S} !== 33'd2688) begin
          n_fail++;
          $display("FAIL basic_sum: got cout=%b s=%0d required 0/2688", bus.Cout, bus.S);
        end
      end
    end
  endtask

  task automatic test_carry();
    logic [31:0] ta [3] = '{32'd1298, 32'hFFFFFFFF, 32'h7FFFFFFF};
    logic [31:0] tb [3] = '{32'hFFFFFFFF, 32'd0, 32'd1};
    logic        tc [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] ts [3] = '{32'h00000511, 32'd0, 32'h80000000};
    logic        tco[3] = '{1'b1, 1'b1, 1'b0};
    logic        tov[3] = '{1'b0, 1'b0, 1'b1};
    bit seen;
    for (int v = 0; v < 3; v++) begin
      @(negedge CLK);
      bus.A = ta[v]; bus.B = tb[v]; bus.CIN = tc[v]; bus.IN_VALID = 1'b1; bus.OUT_READY = 1'b1;
      @(posedge CLK);
      seen = 1'b0;
      for (int w = 0; w < 8 && !seen; w++) begin
        @(negedge CLK);
        bus.IN_VALID = 1'b0;
        seen = bus.OUT_VALID;
      end
      n_checks++;
      if (!seen) begin
        n_fail++; $display("FAIL carry_timeout: vector %0d no result within 8 cycles", v);
      end else if ({bus.Cout, bus.S} !== {tco[v], ts[v]}) begin
        n_fail++;
        $display("FAIL carry_sum: vector %0d got cout=%b s=%h required %b/%h",
                 v, bus.Cout, bus.S, tco[v], ts[v]);
      end
`ifdef CLA_PIPE_OVF_EN
      n_checks++;
      if (bus.OVF !== tov[v]) begin
        n_fail++; $display("FAIL carry_ovf: vector %0d got %b required %b", v, bus.OVF, tov[v]);
      end
`else
      if (tov[v] && !seen) $display("note: overflow vector %0d not observed", v);
`endif
    end
  endtask

  task automatic test_back_to_back();
    op_t op;
    int  sent = 0, got = 0;
    bit  prev_v = 1'b0;
    bus.OUT_READY = 1'b1;
    for (int cyc = 0; cyc < 64 && got < 16; cyc++) begin
      @(negedge CLK);
      if (bus.OUT_VALID) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: s=%h with nothing pending", bus.S);
        end else begin
          op = exp_q.pop_front();
          if ({bus.Cout, bus.S} !== ref32(op)) begin
            n_fail++;
            $display("FAIL b2b_sum: result %0d got %h required %h", got, {bus.Cout, bus.S}, ref32(op));
          end
`ifdef CLA_PIPE_OVF_EN
          if (bus.OVF !== ref_ovf(op)) begin
            n_fail++; $display("FAIL b2b_ovf: result %0d got %b required %b", got, bus.OVF, ref_ovf(op));
          end
`endif
        end
        if (got > 0) begin
          n_checks++;
          if (!prev_v) begin n_fail++; $display("FAIL b2b_gap: gap before result %0d got 0 required 1", got); end
        end
        got++;
      end
      prev_v = bus.OUT_VALID;
      if (sent < 16) begin
        op = rand_op();
        bus.A = op.a; bus.B = op.b; bus.CIN = op.c; bus.IN_VALID = 1'b1;
      end else begin
        bus.IN_VALID = 1'b0;
      end
      #1;
      n_checks++;
      if (bus.IN_READY !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b required 1", bus.IN_READY); end
      if (bus.IN_VALID && bus.IN_READY) begin exp_q.push_back(op); sent++; end
    end
    n_checks++;
    if (got != 16) begin n_fail++; $display("FAIL b2b_count: got %0d results required 16", got); end
  endtask

  task automatic test_backpressure();
    op_t op, nxt;
    int  sent = 0, got = 0, occ = 0, stall_left = 10;
    bit  seen = 1'b0, pop;
    logic exp_rdy;
    for (int cyc = 0; cyc < 100 && got < 6; cyc++) begin
      @(negedge CLK);
      if (bus.OUT_VALID) seen = 1'b1;
      if (seen && stall_left > 0) begin
        bus.OUT_READY = 1'b0;
        stall_left--;
        n_checks++;
        if (bus.OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b required 1", bus.OUT_VALID); end
      end else begin
        bus.OUT_READY = 1'b1;
      end
      pop = 1'b0;
      if (bus.OUT_VALID) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra: s=%h with nothing pending", bus.S);
        end else begin
          op = exp_q[0];
          if ({bus.Cout, bus.S} !== ref32(op)) begin
            n_fail++;
            $display("FAIL bp_sum: result %0d got %h required %h", got, {bus.Cout, bus.S}, ref32(op));
          end
          if (bus.OUT_READY) begin void'(exp_q.pop_front()); got++; pop = 1'b1; end
        end
      end
      if (sent < 6) begin
        nxt = rand_op();
        bus.A = nxt.a; bus.B = nxt.b; bus.CIN = nxt.c; bus.IN_VALID = 1'b1;
      end else begin
        bus.IN_VALID = 1'b0;
      end
      #1;
      exp_rdy = (occ < 4) || bus.OUT_READY;
      n_checks++;
      if (bus.IN_READY !== exp_rdy) begin
        n_fail++;
        $display("FAIL bp_ready: occupancy %0d out_ready %b got %b required %b",
                 occ, bus.OUT_READY, bus.IN_READY, exp_rdy);
      end
      if (bus.IN_VALID && bus.IN_READY) begin exp_q.push_back(nxt); sent++; occ++; end
      if (pop) occ--;
    end
    n_checks++;
    if (got != 6) begin n_fail++; $display("FAIL bp_count: got %0d results required 6", got); end
    bus.IN_VALID = 1'b0; bus.OUT_READY = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL bp_dup: cycle %0d out_valid=%b required 0", i, bus.OUT_VALID); end
    end
  endtask

  task automatic test_bubbles_reset();
    op_t op;
    int  sent = 0, got = 0;
    bus.OUT_READY = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge CLK);
      if (bus.OUT_VALID) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bub_extra: s=%h with nothing pending", bus.S);
        end else begin
          op = exp_q.pop_front();
          if ({bus.Cout, bus.S} !== ref32(op)) begin
            n_fail++;
            $display("FAIL bub_sum: result %0d got %h required %h", got, {bus.Cout, bus.S}, ref32(op));
          end
        end
        got++;
      end
      if (sent < 5 && (cyc % 2) == 0) begin
        op = rand_op();
        bus.A = op.a; bus.B = op.b; bus.CIN = op.c; bus.IN_VALID = 1'b1;
      end else begin
        bus.IN_VALID = 1'b0;
      end
      #1;
      if (bus.IN_VALID && bus.IN_READY) begin exp_q.push_back(op); sent++; end
    end
    n_checks++;
    if (got != 5) begin n_fail++; $display("FAIL bub_count: got %0d results required 5", got); end
    // Three operations in flight with the output stalled, then reset between edges.
    bus.OUT_READY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      op = rand_op();
      bus.A = op.a; bus.B = op.b; bus.CIN = op.c; bus.IN_VALID = 1'b1;
    end
    @(negedge CLK);
    bus.IN_VALID = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (bus.OUT_VALID !== 1'b1) begin n_fail++; $display("FAIL rst_prefill: out_valid=%b required 1", bus.OUT_VALID); end
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if ({bus.OUT_VALID, bus.Cout, bus.S} !== 34'd0) begin
      n_fail++;
      $display("FAIL rst_async: valid/cout/s=%b/%b/%h required 0/0/0", bus.OUT_VALID, bus.Cout, bus.S);
    end
    exp_q.delete();
    @(negedge CLK);
    RST_N = 1'b1; bus.OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      n_checks++;
      if (bus.OUT_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_stale: cycle %0d out_valid=%b required 0", i, bus.OUT_VALID); end
    end
  endtask

  task automatic test_sweep();
    logic [15:0] a16 [1000];
    logic [15:0] b16 [1000];
    logic        c16 [1000];
    logic [63:0] a64 [1000];
    logic [63:0] b64 [1000];
    logic        c64 [1000];
    logic [16:0] e16;
    logic [64:0] e64;
    int j;
    for (int i = 0; i < 1000; i++) begin
      a16[i] = 16'($urandom); b16[i] = 16'($urandom); c16[i] = 1'($urandom_range(1, 0));
      a64[i] = {$urandom, $urandom}; b64[i] = {$urandom, $urandom}; c64[i] = 1'($urandom_range(1, 0));
    end
    for (int t = 0; t < 1004; t++) begin
      @(negedge CLK);
      // Latency-4 pipes: result of vector t-4 is visible now.
      n_checks++;
      if (bus16.OUT_VALID !== (t >= 4) || bus64.OUT_VALID !== (t >= 4)) begin
        n_fail++;
        $display("FAIL sweep_valid4: t=%0d w16=%b w64=%b required %b", t, bus16.OUT_VALID,
                 bus64.OUT_VALID, t >= 4);
      end
      if (t >= 4) begin
        j = t - 4;
        e16 = {1'b0, a16[j]} + {1'b0, b16[j]} + {16'd0, c16[j]};
        e64 = {1'b0, a64[j]} + {1'b0, b64[j]} + {64'd0, c64[j]};
        n_checks++;
        if ({bus16.Cout, bus16.S} !== e16) begin
          n_fail++; $display("FAIL sweep_w16g4: vec %0d got %h required %h", j, {bus16.Cout, bus16.S}, e16);
        end
        n_checks++;
        if ({bus64.Cout, bus64.S} !== e64) begin
          n_fail++; $display("FAIL sweep_w64g16: vec %0d got %h required %h", j, {bus64.Cout, bus64.S}, e64);
        end
      end
      n_checks++;
      if (bus1.OUT_VALID !== (t >= 1 && t <= 1000)) begin
        n_fail++; $display("FAIL sweep_valid1: t=%0d got %b required %b", t, bus1.OUT_VALID, t >= 1 && t <= 1000);
      end
      if (t >= 1 && t <= 1000) begin
        j = t - 1;
        e16 = {1'b0, a16[j]} + {1'b0, b16[j]} + {16'd0, c16[j]};
        n_checks++;
        if ({bus1.Cout, bus1.S} !== e16) begin
          n_fail++; $display("FAIL sweep_w16g16: vec %0d got %h required %h", j, {bus1.Cout, bus1.S}, e16);
        end
      end
      if (t < 1000) begin
        bus16.A = a16[t]; bus16.B = b16[t]; bus16.CIN = c16[t]; bus16.IN_VALID = 1'b1;
        bus1.A  = a16[t]; bus1.B  = b16[t]; bus1.CIN  = c16[t]; bus1.IN_VALID  = 1'b1;
        bus64.A = a64[t]; bus64.B = b64[t]; bus64.CIN = c64[t]; bus64.IN_VALID = 1'b1;
      end else begin
        bus16.IN_VALID = 1'b0; bus1.IN_VALID = 1'b0; bus64.IN_VALID = 1'b0;
      end
    end
  endtask

  initial begin
    bus16.A = '0; bus16.B = '0; bus16.CIN = 1'b0; bus16.IN_VALID = 1'b0; bus16.OUT_READY = 1'b1;
    bus64.A = '0; bus64.B = '0; bus64.CIN = 1'b0; bus64.IN_VALID = 1'b0; bus64.OUT_READY = 1'b1;
    bus1.A  = '0; bus1.B  = '0; bus1.CIN  = 1'b0; bus1.IN_VALID  = 1'b0; bus1.OUT_READY  = 1'b1;
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_backpressure();
    test_bubbles_reset();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
